// File: rtl/cortex_m0_pkg.sv
// Shared types and constants for the Cortex-M0 style interrupt arbiter.
package cortex_m0_pkg;

    localparam int unsigned PRIO_W       = 2;
    localparam logic [5:0]  EXC_NMI      = 6'd2;
    localparam logic [5:0]  EXC_IRQ_BASE = 6'd16;
    localparam logic [2:0]  PRIO_NONE    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACKED
    } arb_state_t;

    function automatic logic [5:0] irq_exc_num(input int unsigned line);
        return EXC_IRQ_BASE + 6'(line);
    endfunction

endpackage

// File: rtl/cortex_m0_prio_select.sv
// Combinational finder: lowest priority value among valid lines, ties to lowest index.
module cortex_m0_prio_select
    import cortex_m0_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]        i_valid,
    input  logic [PRIO_W*N-1:0] i_prio,
    output logic                o_found,
    output logic [4:0]          o_idx,
    output logic [PRIO_W-1:0]   o_prio
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        o_prio  = '1;
        // strict compare keeps the first (lowest-index) line on equal priority
        for (int unsigned i = 0; i < N; i++) begin
            if (i_valid[i] && (!o_found || (i_prio[PRIO_W*i +: PRIO_W] < o_prio))) begin
                o_found = 1'b1;
                o_idx   = 5'(i);
                o_prio  = i_prio[PRIO_W*i +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/cortex_m0_irq_arbiter.sv
// Pending/active tracking and single-request handshake for NMI plus N external lines.
module cortex_m0_irq_arbiter
    import cortex_m0_pkg::*;
#(
    parameter int N_EXT_INT = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_EXT_INT-1:0]          ext_int,
    input  logic                          nmi,
    input  logic [N_EXT_INT-1:0]          irq_en,
    input  logic [PRIO_W*N_EXT_INT-1:0]   irq_prio,
    input  logic [N_EXT_INT-1:0]          set_pend,
    input  logic [N_EXT_INT-1:0]          clr_pend,
    output logic                          exc_req,
    output logic [5:0]                    exc_num,
    input  logic                          exc_ack,
    input  logic                          exc_ret,
    input  logic [5:0]                    exc_ret_num,
    output logic [N_EXT_INT-1:0]          pending,
    output logic [N_EXT_INT-1:0]          active
);

    arb_state_t             r_state;
    logic                   r_exc_req;
    logic [5:0]             r_exc_num;
    logic [N_EXT_INT-1:0]   r_pending;
    logic [N_EXT_INT-1:0]   r_active;
    logic                   r_nmi_hist;
    logic                   r_nmi_pend;
    logic                   r_nmi_act;

    logic [N_EXT_INT-1:0]   w_sel_line;
    logic [N_EXT_INT-1:0]   w_ret_line;
    logic [N_EXT_INT-1:0]   w_ack_line;
    logic [N_EXT_INT-1:0]   w_set;
    logic [N_EXT_INT-1:0]   w_pend_next;
    logic [N_EXT_INT-1:0]   w_active_next;
    logic                   w_ack;
    logic                   w_ack_nmi;
    logic                   w_ret_nmi;
    logic                   w_nmi_rise;
    logic                   w_nmi_pend_next;
    logic                   w_nmi_act_next;
    logic                   w_latched_live;
    logic                   w_cand_found;
    logic [4:0]             w_cand_idx;
    logic [PRIO_W-1:0]      w_cand_prio;
    logic                   w_act_found;
    logic [4:0]             w_act_idx;
    logic [PRIO_W-1:0]      w_act_prio;
    logic [2:0]             w_exec_prio;
    logic                   w_preempt;
    logic [5:0]             w_cand_num;

    always_comb begin
        w_sel_line = '0;
        w_ret_line = '0;
        for (int unsigned i = 0; i < N_EXT_INT; i++) begin
            w_sel_line[i] = (r_exc_num == irq_exc_num(i));
            w_ret_line[i] = exc_ret && (exc_ret_num == irq_exc_num(i));
        end
    end

    assign w_ack      = (r_state == ST_REQ) && exc_ack;
    assign w_ack_line = {N_EXT_INT{w_ack}} & w_sel_line;
    assign w_ack_nmi  = w_ack && (r_exc_num == EXC_NMI);
    assign w_ret_nmi  = exc_ret && (exc_ret_num == EXC_NMI);

    // acceptance clears unconditionally; otherwise a set source beats clr_pend
    assign w_set         = (ext_int & ~r_active) | set_pend;
    assign w_pend_next   = ~w_ack_line & (w_set | (r_pending & ~clr_pend));
    assign w_active_next = w_ack_line | (r_active & ~w_ret_line);

    assign w_nmi_rise      = nmi && !r_nmi_hist;
    assign w_nmi_pend_next = !w_ack_nmi && (w_nmi_rise || r_nmi_pend);
    assign w_nmi_act_next  = w_ack_nmi || (r_nmi_act && !w_ret_nmi);

    assign w_latched_live = (r_exc_num == EXC_NMI) ? w_nmi_pend_next
                                                   : |(w_sel_line & w_pend_next & irq_en);

    cortex_m0_prio_select #(.N(N_EXT_INT)) u_cand_sel (
        .i_valid (r_pending & irq_en),
        .i_prio  (irq_prio),
        .o_found (w_cand_found),
        .o_idx   (w_cand_idx),
        .o_prio  (w_cand_prio)
    );

    cortex_m0_prio_select #(.N(N_EXT_INT)) u_exec_sel (
        .i_valid (r_active),
        .i_prio  (irq_prio),
        .o_found (w_act_found),
        .o_idx   (w_act_idx),
        .o_prio  (w_act_prio)
    );

    assign w_exec_prio = w_act_found ? {1'b0, w_act_prio} : PRIO_NONE;
    assign w_preempt   = !r_nmi_act &&
                         (r_nmi_pend || (w_cand_found && ({1'b0, w_cand_prio} < w_exec_prio)));
    assign w_cand_num  = r_nmi_pend ? EXC_NMI : (EXC_IRQ_BASE + {1'b0, w_cand_idx});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_exc_req  <= 1'b0;
            r_exc_num  <= '0;
            r_pending  <= '0;
            r_active   <= '0;
            r_nmi_hist <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_nmi_act  <= 1'b0;
        end else begin
            r_pending  <= w_pend_next;
            r_active   <= w_active_next;
            r_nmi_hist <= nmi;
            r_nmi_pend <= w_nmi_pend_next;
            r_nmi_act  <= w_nmi_act_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_preempt) begin
                        r_state   <= ST_REQ;
                        r_exc_req <= 1'b1;
                        r_exc_num <= w_cand_num;
                    end
                end
                ST_REQ: begin
                    if (exc_ack) begin
                        r_state   <= ST_ACKED;
                        r_exc_req <= 1'b0;
                    end else if (!w_latched_live) begin
                        r_state   <= ST_IDLE;
                        r_exc_req <= 1'b0;
                    end
                end
                ST_ACKED: r_state <= ST_IDLE;
                default: begin
                    r_state   <= ST_IDLE;
                    r_exc_req <= 1'b0;
                end
            endcase
        end
    end

    assign exc_req = r_exc_req;
    assign exc_num = r_exc_num;
    assign pending = r_pending;
    assign active  = r_active;

endmodule

// File: tb/tb_cortex_m0_irq_arbiter.sv
// Directed scenarios plus randomized traffic checked against a rule-level reference model.
module tb_cortex_m0_irq_arbiter;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   ext_int = '0;
    logic           nmi = 1'b0;
    logic [N-1:0]   irq_en = '1;
    logic [2*N-1:0] irq_prio = '1;
    logic [N-1:0]   set_pend = '0;
    logic [N-1:0]   clr_pend = '0;
    logic           exc_req;
    logic [5:0]     exc_num;
    logic           exc_ack = 1'b0;
    logic           exc_ret = 1'b0;
    logic [5:0]     exc_ret_num = '0;
    logic [N-1:0]   pending;
    logic [N-1:0]   active;

    int n_checks = 0;
    int n_errors = 0;

    cortex_m0_irq_arbiter #(.N_EXT_INT(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_int     (ext_int),
        .nmi         (nmi),
        .irq_en      (irq_en),
        .irq_prio    (irq_prio),
        .set_pend    (set_pend),
        .clr_pend    (clr_pend),
        .exc_req     (exc_req),
        .exc_num     (exc_num),
        .exc_ack     (exc_ack),
        .exc_ret     (exc_ret),
        .exc_ret_num (exc_ret_num),
        .pending     (pending),
        .active      (active)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_REQ, M_ACKED} mmode_t;
    bit     m_pend [N];
    bit     m_act  [N];
    bit     m_nmi_pend, m_nmi_act, m_nmi_hist, m_req;
    int     m_num;
    mmode_t m_mode;

    function automatic int prio_of(input int i);
        return int'(irq_prio[2*i +: 2]);
    endfunction

    function automatic logic [N-1:0] pack(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    // Next-state of the whole arbiter from the rules, given the inputs about to be sampled
    function automatic void model_step();
        bit np [N];
        bit na [N];
        int exec_p, cnum, acked;
        bit pre, rise, nnp, nna, ack, live;
        if (reset) begin
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_act[i] = 0; end
            m_nmi_pend = 0; m_nmi_act = 0; m_nmi_hist = 0; m_req = 0; m_num = 0; m_mode = M_IDLE;
            return;
        end
        ack   = (m_mode == M_REQ) && exc_ack;
        acked = (ack && m_num >= 16) ? m_num - 16 : -1;
        exec_p = 4;
        for (int i = 0; i < N; i++) if (m_act[i] && prio_of(i) < exec_p) exec_p = prio_of(i);
        pre = 0; cnum = 0;
        if (!m_nmi_act) begin
            if (m_nmi_pend) begin pre = 1; cnum = 2; end
            else for (int p = 0; p < exec_p && !pre; p++)
                for (int i = 0; i < N && !pre; i++)
                    if (m_pend[i] && irq_en[i] && prio_of(i) == p) begin pre = 1; cnum = 16 + i; end
        end
        for (int i = 0; i < N; i++) begin
            if (i == acked) np[i] = 0;
            else if ((ext_int[i] && !m_act[i]) || set_pend[i]) np[i] = 1;
            else if (clr_pend[i]) np[i] = 0;
            else np[i] = m_pend[i];
            na[i] = (i == acked) || (m_act[i] && !(exc_ret && exc_ret_num == 6'(16 + i)));
        end
        rise = nmi && !m_nmi_hist;
        nnp  = (ack && m_num == 2) ? 0 : (rise || m_nmi_pend);
        nna  = (ack && m_num == 2) || (m_nmi_act && !(exc_ret && exc_ret_num == 6'd2));
        case (m_mode)
            M_IDLE: if (pre) begin m_mode = M_REQ; m_req = 1; m_num = cnum; end
            M_REQ: begin
                live = (m_num == 2) ? nnp : (np[m_num-16] && irq_en[m_num-16]);
                if (ack) begin m_mode = M_ACKED; m_req = 0; end
                else if (!live) begin m_mode = M_IDLE; m_req = 0; end
            end
            default: m_mode = M_IDLE;
        endcase
        m_pend = np; m_act = na;
        m_nmi_pend = nnp; m_nmi_act = nna; m_nmi_hist = nmi;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int i, input int p);
        irq_prio[2*i +: 2] = 2'(p);
    endtask

    task automatic do_reset();
        reset = 1; ext_int = '0; nmi = 0; irq_en = '1; irq_prio = '1;
        set_pend = '0; clr_pend = '0; exc_ack = 0; exc_ret = 0; exc_ret_num = '0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (exc_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %0b want 0", exc_req); end
        n_checks++; if (exc_num !== 6'd0) begin n_errors++; $display("FAIL reset_num got %0d want 0", exc_num); end
        n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL reset_pend got %h want 0", pending); end
        n_checks++; if (active !== '0) begin n_errors++; $display("FAIL reset_act got %h want 0", active); end
    endtask

    task automatic test_basic();
        do_reset();
        set_prio(3, 2); ext_int[3] = 1;
        tick();
        n_checks++; if (pending[3] !== 1'b1 || exc_req !== 1'b0) begin n_errors++; $display("FAIL basic_pend got p=%0b r=%0b want p=1 r=0", pending[3], exc_req); end
        tick();
        n_checks++; if (exc_req !== 1'b1) begin n_errors++; $display("FAIL basic_req got %0b want 1", exc_req); end
        n_checks++; if (exc_num !== 6'd19) begin n_errors++; $display("FAIL basic_num got %0d want 19", exc_num); end
        exc_ack = 1; tick(); exc_ack = 0;
        n_checks++; if (active[3] !== 1'b1 || pending[3] !== 1'b0 || exc_req !== 1'b0) begin n_errors++; $display("FAIL basic_ack got a=%0b p=%0b r=%0b want 1 0 0", active[3], pending[3], exc_req); end
        tick();
        exc_ret = 1; exc_ret_num = 6'd19; tick(); exc_ret = 0;
        n_checks++; if (active[3] !== 1'b0 || pending[3] !== 1'b0) begin n_errors++; $display("FAIL basic_ret got a=%0b p=%0b want 0 0", active[3], pending[3]); end
        tick();
        n_checks++; if (pending[3] !== 1'b1) begin n_errors++; $display("FAIL basic_repend got %0b want 1", pending[3]); end
    endtask

    task automatic test_tie();
        do_reset();
        set_prio(5, 1); set_prio(9, 1);
        set_pend[5] = 1; set_pend[9] = 1; tick(); set_pend = '0;
        tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd21) begin n_errors++; $display("FAIL tie_num got r=%0b n=%0d want 1 21", exc_req, exc_num); end
        exc_ack = 1; tick(); exc_ack = 0;
        tick(); tick();
        n_checks++; if (exc_req !== 1'b0 || pending[9] !== 1'b1) begin n_errors++; $display("FAIL tie_block got r=%0b p9=%0b want 0 1", exc_req, pending[9]); end
        exc_ret = 1; exc_ret_num = 6'd21; tick(); exc_ret = 0;
        tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd25) begin n_errors++; $display("FAIL tie_next got r=%0b n=%0d want 1 25", exc_req, exc_num); end
    endtask

    task automatic test_preempt();
        do_reset();
        set_prio(2, 1); ext_int[2] = 1;
        tick(); tick();
        exc_ack = 1; tick(); exc_ack = 0;
        set_prio(7, 1); set_pend[7] = 1; tick(); set_pend = '0;
        tick(); tick();
        n_checks++; if (exc_req !== 1'b0 || active[2] !== 1'b1) begin n_errors++; $display("FAIL preempt_equal got r=%0b a2=%0b want 0 1", exc_req, active[2]); end
        set_prio(7, 0); tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd23) begin n_errors++; $display("FAIL preempt_higher got r=%0b n=%0d want 1 23", exc_req, exc_num); end
    endtask

    task automatic test_drop();
        do_reset();
        set_prio(4, 0); set_pend[4] = 1; tick(); set_pend = '0;
        tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd20) begin n_errors++; $display("FAIL drop_req got r=%0b n=%0d want 1 20", exc_req, exc_num); end
        clr_pend[4] = 1; tick(); clr_pend = '0;
        n_checks++; if (exc_req !== 1'b0 || pending[4] !== 1'b0) begin n_errors++; $display("FAIL drop_clr got r=%0b p=%0b want 0 0", exc_req, pending[4]); end
        tick();
        n_checks++; if (exc_req !== 1'b0) begin n_errors++; $display("FAIL drop_idle got %0b want 0", exc_req); end
    endtask

    task automatic test_nmi();
        do_reset();
        set_prio(0, 0); set_pend[0] = 1; tick(); set_pend = '0;
        tick();
        exc_ack = 1; tick(); exc_ack = 0;
        tick();
        nmi = 1; tick(); tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd2) begin n_errors++; $display("FAIL nmi_req got r=%0b n=%0d want 1 2", exc_req, exc_num); end
        exc_ack = 1; tick(); exc_ack = 0;
        nmi = 0; tick();
        nmi = 1; tick(); tick(); tick();
        n_checks++; if (exc_req !== 1'b0) begin n_errors++; $display("FAIL nmi_blocked got %0b want 0", exc_req); end
        exc_ret = 1; exc_ret_num = 6'd2; tick(); exc_ret = 0;
        tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd2) begin n_errors++; $display("FAIL nmi_again got r=%0b n=%0d want 1 2", exc_req, exc_num); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_prio(6, 1); set_pend[6] = 1; tick(); set_pend = '0;
        tick();
        exc_ack = 1; tick(); exc_ack = 0;
        set_prio(8, 0); set_pend[8] = 1; tick(); set_pend = '0;
        tick();
        n_checks++; if (exc_req !== 1'b1 || exc_num !== 6'd24) begin n_errors++; $display("FAIL rstmid_req got r=%0b n=%0d want 1 24", exc_req, exc_num); end
        reset = 1; exc_ack = 1; tick(); reset = 0; exc_ack = 0;
        n_checks++; if (exc_req !== 1'b0 || pending !== '0 || active !== '0 || exc_num !== 6'd0) begin
            n_errors++; $display("FAIL rstmid_clear got r=%0b p=%h a=%h n=%0d want 0 0 0 0", exc_req, pending, active, exc_num); end
    endtask

    task automatic test_random();
        int start, k;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) ext_int[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) nmi = ~nmi;
            if ($urandom_range(0, 49) == 0) irq_prio = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) irq_en = ~($urandom & $urandom & $urandom);
            set_pend = '0; clr_pend = '0;
            if ($urandom_range(0, 5) == 0) set_pend[$urandom_range(0, N-1)] = 1'b1;
            if ($urandom_range(0, 5) == 0) clr_pend[$urandom_range(0, N-1)] = 1'b1;
            exc_ack = m_req && ($urandom_range(0, 2) == 0);
            exc_ret = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 9);
            if (k == 0) exc_ret_num = 6'd2;
            else if (k == 1) exc_ret_num = 6'($urandom_range(0, 63));
            else begin
                start = $urandom_range(0, N-1);
                exc_ret_num = 6'(16 + start);
                for (int j = 0; j < N; j++) if (m_act[(start + j) % N]) begin exc_ret_num = 6'(16 + (start + j) % N); break; end
            end
            tick();
            n_checks++; if (exc_req !== m_req) begin n_errors++; $display("FAIL rand_req c=%0d got %0b want %0b", c, exc_req, m_req); end
            n_checks++; if (exc_num !== 6'(m_num)) begin n_errors++; $display("FAIL rand_num c=%0d got %0d want %0d", c, exc_num, m_num); end
            n_checks++; if (pending !== pack(m_pend)) begin n_errors++; $display("FAIL rand_pend c=%0d got %h want %h", c, pending, pack(m_pend)); end
            n_checks++; if (active !== pack(m_act)) begin n_errors++; $display("FAIL rand_act c=%0d got %h want %h", c, active, pack(m_act)); end
        end
        reset = 0; exc_ack = 0; exc_ret = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_preempt();
        test_drop();
        test_nmi();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
